square_wave_meter: RTL and testbench
====================================

Name: square_wave_meter

Overview:
- Receive-side counterpart to the team's square-wave frequency divider. Samples a square-wave input in the `clk` domain.
- Measures the period and the high time in `clk` cycles for each full cycle of the input.
- Raises a one-cycle `valid` strobe for each completed measurement.
- Flags loss of signal when no expected edge arrives within a timeout. Used by benches and as a self-check monitor beside generated clocks.

Parameters:
- CNT_W, 16, width of the measurement counter and of the `period` and `high_time` outputs.
- TIMEOUT, 1000, cycles without an expected edge before loss of signal is declared; legal range 4 .. 2^CNT_W-1.

Ports:
- clk  input  1  system clock; all logic on posedge.
- rst  input  1  reset, synchronous, active-high.
- square_wave  input  1  measured signal.
- period  output  CNT_W  cycles between the last two rising edges; held between updates.
- high_time  output  CNT_W  cycles from a rising edge to the following falling edge; held between updates.
- valid  output  1  one-cycle pulse; `period` and `high_time` were updated this cycle.
- no_signal  output  1  level; high until the first measurement completes and again after any timeout.

Behaviour:
- Interface: one clock, `clk`. Reset `rst` is synchronous and active-high.
- Reset values: `period`=0, `high_time`=0, `valid`=0, `no_signal`=1, state=WAIT_RISE, `cnt`=0, `sq_s`=0, `sq_d`=0.
- Input stage: `sq_s` registers `square_wave`; `sq_d` registers `sq_s`.
  - `rise` = `sq_s` & ~`sq_d`.
  - `fall` = ~`sq_s` & `sq_d`.
- `cnt`:
  - Loads 1 on `rise`.
  - Otherwise increments, saturating at TIMEOUT.
  - The visible `cnt` at the next rise equals the period P. The visible `cnt` at the fall equals the high time H.
- States:
  - WAIT_RISE: `rise` -> HIGH. `fall` is ignored. No output update.
  - HIGH: `fall` -> LOW and `hi_cap` <= `cnt`. If `cnt`==TIMEOUT with no `fall` -> WAIT_RISE.
  - LOW: `rise` -> HIGH, with:
    - `period` <= `cnt`, `high_time` <= `hi_cap`.
    - `valid` <= 1, `no_signal` <= 0.
    - `cnt` <= 1.
  - LOW timeout: if `cnt`==TIMEOUT with no `rise` -> WAIT_RISE.
- Timeout side effects: `no_signal` <= 1. `period` and `high_time` keep their last values. `valid` stays 0.
- Simultaneous edge and timeout in the same cycle: the edge wins; no timeout.
- First measurement after reset or timeout: needs rise, fall, rise. The first rise only arms the meter.
- Latency: an input edge sampled at posedge k produces the `valid` pulse visible after posedge k+1 (2 cycles).
- Minimum measurable half-period is 1 cycle; period >= 2. Narrower pulses that the input stage never samples are missed; this is expected.
- `rst` mid-measurement discards partial counts and returns all state and outputs to reset values on the next posedge.

Optional Feature:
- Macro: SQW_SYNC_EN.
- Defined: two extra flops in front of `sq_s` form a metastability synchronizer for an asynchronous `square_wave`. Edge-to-`valid` latency becomes 4 cycles. Both sync flops reset to 0.
- Not defined: `square_wave` is assumed synchronous to `clk`; latency is 2 cycles.
- Measured `period` and `high_time` values are identical in both builds.

Test Plan:
- Reset, then a square wave with period 20 and 10 high -> first `valid` after the second rise; `period`=20, `high_time`=10, `no_signal` falls to 0. `valid` repeats every 20 cycles with the same values.
- Period 40, 10 high -> `period`=40, `high_time`=10. Change to period 6, 3 high -> the next `valid` reports 6/3; no stale mix of old and new values.
- Input held at 1 after a valid measurement (TIMEOUT=1000) -> `no_signal`=1 exactly 1000 cycles after the last rise. `period` and `high_time` keep their last values. After restart, no `valid` until a full rise-fall-rise.
- Assert `rst` for 1 cycle while in the HIGH state -> all outputs 0 and `no_signal`=1 on the next cycle. A subsequent 20/10 wave measures correctly.
- Fastest input, toggling every cycle (period 2, high 1) -> a `valid` every 2 cycles with `period`=2, `high_time`=1.
- Latency check, run in both builds: rise sampled at posedge k, measurement complete -> `valid` after posedge k+1 without SQW_SYNC_EN and after k+3 with it; values identical.

Source files
------------

// File: rtl/square_wave_meter.sv
// square_wave_meter: measures period and high time of a square wave in clk cycles.
// A valid measurement needs rise, fall, rise; the first rise only arms the meter.
// no_signal is raised at reset and whenever an expected edge fails to arrive
// within TIMEOUT cycles.
// Optional macro SQW_SYNC_EN: adds a two-flop synchronizer ahead of the edge
// detector for an asynchronous square_wave (edge-to-valid latency 4 instead of 2).
module square_wave_meter #(
    parameter int CNT_W   = 16,
    parameter int TIMEOUT = 1000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             square_wave,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] high_time,
    output logic             valid,
    output logic             no_signal
);

    typedef enum logic [1:0] {
        WAIT_RISE = 2'd0,
        HIGH      = 2'd1,
        LOW       = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] ONE_C     = CNT_W'(1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] hi_cap_q, hi_cap_d;
    logic [CNT_W-1:0] period_q, period_d;
    logic [CNT_W-1:0] high_time_q, high_time_d;
    logic             valid_q, valid_d;
    logic             no_signal_q, no_signal_d;
    logic             sq_s_q, sq_d_q;
    logic             sq_in;
    logic             rise;
    logic             fall;

`ifdef SQW_SYNC_EN
    logic sync1_q, sync2_q;

    // Two-flop synchronizer so an asynchronous input settles before edge detection
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= square_wave;
            sync2_q <= sync1_q;
        end
    end

    assign sq_in = sync2_q;
`else
    assign sq_in = square_wave;
`endif

    assign rise = sq_s_q & ~sq_d_q;
    assign fall = ~sq_s_q & sq_d_q;

    // Next-state logic: counter, measurement FSM and registered outputs
    always_comb begin
        state_d     = state_q;
        hi_cap_d    = hi_cap_q;
        period_d    = period_q;
        high_time_d = high_time_q;
        valid_d     = 1'b0;
        no_signal_d = no_signal_q;

        if (rise) begin
            cnt_d = ONE_C;
        end else if (cnt_q != TIMEOUT_C) begin
            cnt_d = cnt_q + ONE_C;
        end else begin
            cnt_d = cnt_q;
        end

        case (state_q)
            WAIT_RISE: begin
                if (rise) begin
                    state_d = HIGH;
                end
            end
            HIGH: begin
                if (fall) begin
                    state_d  = LOW;
                    hi_cap_d = cnt_q;
                end else if (cnt_q == TIMEOUT_C) begin
                    state_d     = WAIT_RISE;
                    no_signal_d = 1'b1;
                end
            end
            LOW: begin
                if (rise) begin
                    state_d     = HIGH;
                    period_d    = cnt_q;
                    high_time_d = hi_cap_q;
                    valid_d     = 1'b1;
                    no_signal_d = 1'b0;
                end else if (cnt_q == TIMEOUT_C) begin
                    state_d     = WAIT_RISE;
                    no_signal_d = 1'b1;
                end
            end
            default: begin
                state_d = WAIT_RISE;
            end
        endcase
    end

    // State registers with synchronous reset back to the unarmed, no-signal condition
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= WAIT_RISE;
            cnt_q       <= '0;
            hi_cap_q    <= '0;
            period_q    <= '0;
            high_time_q <= '0;
            valid_q     <= 1'b0;
            no_signal_q <= 1'b1;
            sq_s_q      <= 1'b0;
            sq_d_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            hi_cap_q    <= hi_cap_d;
            period_q    <= period_d;
            high_time_q <= high_time_d;
            valid_q     <= valid_d;
            no_signal_q <= no_signal_d;
            sq_s_q      <= sq_in;
            sq_d_q      <= sq_s_q;
        end
    end

    assign period    = period_q;
    assign high_time = high_time_q;
    assign valid     = valid_q;
    assign no_signal = no_signal_q;

endmodule

// File: tb/tb_square_wave_meter.sv
// tb_square_wave_meter: drives directed and random square waves into
// square_wave_meter and compares every output every cycle against an
// edge-timestamp reference model.
module tb_square_wave_meter;

    localparam int CNT_W   = 16;
    localparam int TIMEOUT = 1000;
`ifdef SQW_SYNC_EN
    localparam int SYNC = 2;
`else
    localparam int SYNC = 0;
`endif

    logic             clk;
    logic             rst;
    logic             square_wave;
    logic [CNT_W-1:0] period;
    logic [CNT_W-1:0] high_time;
    logic             valid;
    logic             no_signal;

    int nVectors;
    int nMiscompares;
    int cycleCount;

    // Reference model state: input history and edge timestamps (sample indices)
    int  hist[$];
    int  edgeIdx;
    bit  armed;
    bit  fallSeen;
    int  riseTime;
    int  fallTime;
    int  mPeriod;
    int  mHigh;
    bit  mValid;
    bit  mNoSig;

    square_wave_meter #(
        .CNT_W  (CNT_W),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .square_wave(square_wave),
        .period     (period),
        .high_time  (high_time),
        .valid      (valid),
        .no_signal  (no_signal)
    );

    // Free-running clock, period 10
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string tag, input int got, input int expected);
        nVectors++;
        if (got != expected) begin
            nMiscompares++;
            $display("[TB] FAIL %s at cycle %0d: got %0d, expected %0d", tag, cycleCount, got, expected);
        end
    endtask

    task automatic modelReset();
        hist.delete();
        edgeIdx  = 0;
        armed    = 1'b0;
        fallSeen = 1'b0;
        riseTime = 0;
        fallTime = 0;
        mPeriod  = 0;
        mHigh    = 0;
        mValid   = 1'b0;
        mNoSig   = 1'b1;
    endtask

    // Advance the model by one clock edge given the value just applied
    task automatic modelStep(input bit v);
        int s;
        int cur;
        int prv;
        hist.push_back(int'(v));
        s   = edgeIdx - 1 - SYNC;
        cur = (s >= 0) ? hist[s] : 0;
        prv = (s >= 1) ? hist[s-1] : 0;
        mValid = 1'b0;
        if (cur == 1 && prv == 0) begin
            if (armed && fallSeen) begin
                mPeriod = s - riseTime;
                mHigh   = fallTime - riseTime;
                mValid  = 1'b1;
                mNoSig  = 1'b0;
            end
            armed    = 1'b1;
            fallSeen = 1'b0;
            riseTime = s;
        end else if (cur == 0 && prv == 1) begin
            if (armed && !fallSeen) begin
                fallSeen = 1'b1;
                fallTime = s;
            end
        end else if (armed && (s - riseTime) >= TIMEOUT) begin
            armed  = 1'b0;
            mNoSig = 1'b1;
        end
        edgeIdx++;
    endtask

    task automatic compareAll();
        checkOutput("valid", int'(valid), int'(mValid));
        checkOutput("no_signal", int'(no_signal), int'(mNoSig));
        checkOutput("period", int'(period), mPeriod);
        checkOutput("high_time", int'(high_time), mHigh);
    endtask

    // One clock of stimulus: drive input, wait for the edge, compare just after it
    task automatic applyStimulus(input bit v);
        square_wave = v;
        @(posedge clk);
        #1;
        cycleCount++;
        modelStep(v);
        compareAll();
    endtask

    // Synchronous reset pulse of one cycle, then check reset values
    task automatic applyReset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        cycleCount++;
        rst = 1'b0;
        modelReset();
        compareAll();
    endtask

    task automatic applyWave(input int per, input int hi, input int reps);
        for (int r = 0; r < reps; r++) begin
            for (int c = 0; c < per; c++) begin
                applyStimulus(c < hi);
            end
        end
    endtask

    task automatic applyHold(input bit v, input int cycles);
        for (int c = 0; c < cycles; c++) begin
            applyStimulus(v);
        end
    endtask

    initial begin
        int per;
        int hi;
        nVectors     = 0;
        nMiscompares = 0;
        cycleCount   = 0;
        rst          = 1'b1;
        square_wave  = 1'b0;
        modelReset();
        @(posedge clk);
        #1;

        // Reset state, then 20/10 wave
        applyReset();
        applyHold(1'b0, 3);
        applyWave(20, 10, 6);

        // 40/10 then switch to 6/3
        applyWave(40, 10, 3);
        applyWave(6, 3, 5);

        // Held high past the timeout, then restart
        applyHold(1'b1, TIMEOUT + 50);
        applyHold(1'b0, 7);
        applyWave(20, 10, 4);

        // Held low past the timeout
        applyHold(1'b0, TIMEOUT + 20);
        applyWave(20, 10, 3);

        // Reset in the middle of a high phase
        applyHold(1'b1, 5);
        applyReset();
        applyHold(1'b1, 5);
        applyHold(1'b0, 10);
        applyWave(20, 10, 4);

        // Fastest input
        applyWave(2, 1, 12);

        // Randomized segments, occasionally stalling into a timeout
        for (int seg = 0; seg < 60; seg++) begin
            per = $urandom_range(60, 2);
            hi  = $urandom_range(per - 1, 1);
            applyWave(per, hi, $urandom_range(5, 1));
            if ($urandom_range(9, 0) == 0) begin
                applyHold(1'($urandom_range(1, 0)), $urandom_range(TIMEOUT + 30, TIMEOUT - 30));
            end
        end
        applyWave(2, 1, 4);

        $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
        $finish;
    end

endmodule
